// File: rtl/hilo_muldiv_ctrl_pkg.sv
// rtl/hilo_muldiv_ctrl_pkg.sv - shared types and constants for the HI/LO mul/div controller
package hilo_muldiv_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int HILO_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_type_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_SIGN = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Op_Type[1] selects divide, Op_Type[0] selects unsigned.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_radix2_core.sv
// rtl/hilo_muldiv_ctrl_div_radix2_core.sv - iterative unsigned restoring divider, one bit per step
module div_radix2_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // Load on start; otherwise shift the next dividend bit into the partial remainder
    // and keep the difference when it does not borrow. A zero divisor never borrows,
    // which yields an all-ones quotient and the dividend as remainder.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        trial = {rem_q, quo_q[WIDTH-1]};
        diff  = trial - {1'b0, dvs_q};
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            if (!diff[WIDTH]) begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Divider datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO multiply/divide sequencing controller with pipeline stall
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Op_Valid,
    input  logic [1:0]         Op_Type,
    input  logic [WIDTH-1:0]   Src_A,
    input  logic [WIDTH-1:0]   Src_B,
    input  logic               Flush,
    output logic               Stall_Req,
    output logic               Busy,
    output logic               Result_Valid,
    output logic [1:0]         Write_HILO_Enable,
    output logic [2*WIDTH-1:0] Result_HILO
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               mul_signed_q, mul_signed_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               div_start;
    logic               div_step;
    logic [WIDTH-1:0]   div_dividend;
    logic [WIDTH-1:0]   div_divisor;
    logic [WIDTH-1:0]   core_quo;
    logic [WIDTH-1:0]   core_rem;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;

    div_radix2_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .step      (div_step),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

    // Full-width products from the latched operands; operands are pre-extended so the
    // low 2*WIDTH bits of the multiply are the exact result.
    always_comb begin
        prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
        prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    end

    // Signed divide fix-up: quotient negative when signs differ, remainder follows dividend.
    always_comb begin
        quo_fix = (neg_a_q ^ neg_b_q) ? -core_quo : core_quo;
        rem_fix = neg_a_q ? -core_rem : core_rem;
    end

    // Next-state, operand capture and result update; Flush overrides everything.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        mul_signed_d = mul_signed_q;
        neg_a_d      = neg_a_q;
        neg_b_d      = neg_b_q;
        result_d     = result_q;
        div_start    = 1'b0;
        div_step     = 1'b0;
        div_dividend = Src_A;
        div_divisor  = Src_B;
        case (state_q)
            ST_IDLE: begin
                if (Op_Valid && !Flush) begin
                    a_d = Src_A;
                    b_d = Src_B;
                    if (!Op_Type[1]) begin
                        mul_signed_d = op_is_signed(Op_Type);
                        state_d      = ST_MUL;
                    end else begin
                        neg_a_d      = op_is_signed(Op_Type) & Src_A[WIDTH-1];
                        neg_b_d      = op_is_signed(Op_Type) & Src_B[WIDTH-1];
                        div_dividend = neg_a_d ? -Src_A : Src_A;
                        div_divisor  = neg_b_d ? -Src_B : Src_B;
                        div_start    = 1'b1;
                        cnt_d        = '0;
                        state_d      = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                result_d = mul_signed_q ? prod_s : prod_u;
                state_d  = ST_DONE;
            end
            ST_DIV: begin
                div_step = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_SIGN;
                end
            end
            ST_SIGN: begin
                result_d = {rem_fix, quo_fix};
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (Flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    // Controller state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            mul_signed_q <= 1'b0;
            neg_a_q      <= 1'b0;
            neg_b_q      <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mul_signed_q <= mul_signed_d;
            neg_a_q      <= neg_a_d;
            neg_b_q      <= neg_b_d;
            result_q     <= result_d;
        end
    end

    assign Stall_Req = ((state_q == ST_IDLE) && Op_Valid && !Flush)
                     || (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_SIGN);
    assign Busy              = (state_q != ST_IDLE);
    assign Result_Valid      = (state_q == ST_DONE) && !Flush;
    assign Write_HILO_Enable = {2{Result_Valid}};
    assign Result_HILO       = result_q;

endmodule
